// File: rtl/pulse_sched.sv
// Burst scheduler for the sigpulse generator: start/trigger handling, delay,
// period-spaced load strobes and completed-pulse accounting.
module pulse_sched #(
    parameter int _RAM_WIDTH = 32,
    parameter int _CNT_WIDTH = 16
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  cfg_trigMode,
    input  logic [_RAM_WIDTH-1:0] cfg_trigDelay,
    input  logic [_RAM_WIDTH-1:0] cfg_period,
    input  logic [_RAM_WIDTH-1:0] cfg_pulseWidth,
    input  logic [_CNT_WIDTH-1:0] cfg_count,
    input  logic                  io_trigIn,
    output logic                  pulse_en,
    output logic [_RAM_WIDTH-1:0] pulse_width,
    output logic                  pwm_dis,
    input  logic                  pulse_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [_CNT_WIDTH-1:0] pulse_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_DELAY,
        S_FIRE,
        S_GAP
    } state_t;

    localparam logic [_RAM_WIDTH-1:0] RAM_ONE = _RAM_WIDTH'(1);
    localparam logic [_CNT_WIDTH-1:0] CNT_ONE = _CNT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [_RAM_WIDTH-1:0]   dly_q, dly_d;
    logic [_RAM_WIDTH-1:0]   per_q, per_d;
    logic                    seen_q, seen_d;
    logic [_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    dis_q, dis_d;
    logic [_RAM_WIDTH-1:0]   sh_delay_q, sh_delay_d;
    logic [_RAM_WIDTH-1:0]   sh_period_q, sh_period_d;
    logic [_RAM_WIDTH-1:0]   sh_width_q, sh_width_d;
    logic [_CNT_WIDTH-1:0]   sh_count_q, sh_count_d;
    logic                    trig_s1_q, trig_s2_q, trig_s3_q, edge_q;
    logic [_CNT_WIDTH-1:0]   cnt_inc;

    // Trigger synchronizer and registered rising-edge detect (edge visible 2 cycles after capture).
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_s3_q <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            trig_s1_q <= io_trigIn;
            trig_s2_q <= trig_s1_q;
            trig_s3_q <= trig_s2_q;
            edge_q    <= trig_s2_q & ~trig_s3_q;
        end
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state_q     <= S_IDLE;
            dly_q       <= '0;
            per_q       <= '0;
            seen_q      <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dis_q       <= 1'b0;
            sh_delay_q  <= '0;
            sh_period_q <= '0;
            sh_width_q  <= '0;
            sh_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            per_q       <= per_d;
            seen_q      <= seen_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dis_q       <= dis_d;
            sh_delay_q  <= sh_delay_d;
            sh_period_q <= sh_period_d;
            sh_width_q  <= sh_width_d;
            sh_count_q  <= sh_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        per_d       = per_q;
        seen_d      = seen_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        dis_d       = 1'b0;
        sh_delay_d  = sh_delay_q;
        sh_period_d = sh_period_q;
        sh_width_d  = sh_width_q;
        sh_count_d  = sh_count_q;
        cnt_inc     = cnt_q + CNT_ONE;

        case (state_q)
            S_IDLE: begin
                if (cfg_start && !cfg_stop) begin
                    if (cfg_pulseWidth == '0) begin
                        err_d = 1'b1;
                    end else begin
                        sh_delay_d  = cfg_trigDelay;
                        sh_period_d = cfg_period;
                        sh_width_d  = cfg_pulseWidth;
                        sh_count_d  = cfg_count;
                        cnt_d       = '0;
                        if (cfg_trigMode) begin
                            state_d = S_ARM;
                        end else if (cfg_trigDelay == '0) begin
                            state_d = S_FIRE;
                        end else begin
                            state_d = S_DELAY;
                            dly_d   = cfg_trigDelay;
                        end
                    end
                end
            end
            S_ARM: begin
                if (edge_q) begin
                    if (sh_delay_q == '0) begin
                        state_d = S_FIRE;
                    end else begin
                        state_d = S_DELAY;
                        dly_d   = sh_delay_q;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q <= RAM_ONE) begin
                    state_d = S_FIRE;
                end else begin
                    dly_d = dly_q - RAM_ONE;
                end
            end
            S_FIRE: begin
                // Counter runs one behind the period so the next FIRE lands exactly P cycles later.
                per_d   = (sh_period_q == '0) ? '0 : sh_period_q - RAM_ONE;
                seen_d  = 1'b0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (per_q != '0) begin
                    per_d = per_q - RAM_ONE;
                end
                if (pulse_valid) begin
                    cnt_d  = cnt_inc;
                    seen_d = 1'b1;
                    if ((sh_count_q != '0) && (cnt_inc == sh_count_q)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (per_q <= RAM_ONE) begin
                        state_d = S_FIRE;
                    end
                end else if (seen_q && (per_q <= RAM_ONE)) begin
                    state_d = S_FIRE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a coincident pulse_valid.
        if (cfg_stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            dis_d   = 1'b1;
            done_d  = 1'b0;
            cnt_d   = cnt_q;
        end
    end

    assign pulse_en    = (state_q == S_FIRE);
    assign busy        = (state_q != S_IDLE);
    assign pulse_width = sh_width_q;
    assign pwm_dis     = dis_q;
    assign done        = done_q;
    assign cfg_err     = err_q;
    assign pulse_cnt   = cnt_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched with a behavioural sigpulse responder and
// queue-based scoreboard of expected pulse_en / done cycles.
module tb_pulse_sched;

    localparam int RW = 32;
    localparam int CW = 16;

    logic          io_clk = 1'b0;
    logic          io_rst;
    logic          cfg_start, cfg_stop, cfg_trigMode, io_trigIn;
    logic [RW-1:0] cfg_trigDelay, cfg_period, cfg_pulseWidth;
    logic [CW-1:0] cfg_count;
    logic          pulse_en, pwm_dis, busy, done, cfg_err;
    logic          pulse_valid = 1'b0;
    logic [RW-1:0] pulse_width;
    logic [CW-1:0] pulse_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int due    = -1;
    int exp_w  = 0;
    int exp_fire[$];
    int exp_done[$];

    pulse_sched #(._RAM_WIDTH(RW), ._CNT_WIDTH(CW)) dut (
        .io_clk(io_clk), .io_rst(io_rst),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_trigMode(cfg_trigMode),
        .cfg_trigDelay(cfg_trigDelay), .cfg_period(cfg_period),
        .cfg_pulseWidth(cfg_pulseWidth), .cfg_count(cfg_count),
        .io_trigIn(io_trigIn), .pulse_en(pulse_en), .pulse_width(pulse_width),
        .pwm_dis(pwm_dis), .pulse_valid(pulse_valid), .busy(busy), .done(done),
        .cfg_err(cfg_err), .pulse_cnt(pulse_cnt)
    );

    always #5 io_clk = ~io_clk;
    always @(posedge io_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // sigpulse stand-in: valid W+2 cycles after a load, or next cycle after pwm_dis
    always @(negedge io_clk) begin
        pulse_valid = (cyc == due);
        if (pulse_en) due = cyc + int'(pulse_width) + 2;
        if (pwm_dis)  due = cyc + 1;
        if (pulse_en) begin
            if (exp_fire.size() > 0) chk("pulse_en_cycle", cyc, exp_fire.pop_front());
            else                     chk("unexpected_pulse_en", cyc, 64'hFFFF_FFFF);
            chk("pulse_width_at_fire", pulse_width, exp_w);
        end
        if (done) begin
            if (exp_done.size() > 0) chk("done_cycle", cyc, exp_done.pop_front());
            else                     chk("unexpected_done", cyc, 64'hFFFF_FFFF);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge io_clk);
    endtask

    task automatic drive_start(input logic mode, input int d, input int p, input int w,
                               input int n, output int c);
        cfg_trigMode   = mode;
        cfg_trigDelay  = RW'(d);
        cfg_period     = RW'(p);
        cfg_pulseWidth = RW'(w);
        cfg_count      = CW'(n);
        cfg_start      = 1'b1;
        c = cyc;
    endtask

    // Drop start and scramble the config to confirm shadowing.
    task automatic release_start();
        @(negedge io_clk);
        cfg_start      = 1'b0;
        cfg_trigMode   = 1'b1;
        cfg_trigDelay  = RW'(1);
        cfg_period     = RW'(1);
        cfg_pulseWidth = RW'(99);
        cfg_count      = CW'(1);
    endtask

    task automatic burst_a(input string tag);
        int c;
        drive_start(1'b0, 5, 20, 4, 3, c);
        exp_w = 4;
        exp_fire.push_back(c + 6);
        exp_fire.push_back(c + 26);
        exp_fire.push_back(c + 46);
        exp_done.push_back(c + 53);
        release_start();
        tick(6);
        chk({tag, "_busy_mid"}, busy, 1);
        chk({tag, "_width_mid"}, pulse_width, 4);
        tick(54);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_cnt_end"}, pulse_cnt, 3);
        chk({tag, "_fire_left"}, exp_fire.size(), 0);
        chk({tag, "_done_left"}, exp_done.size(), 0);
    endtask

    initial begin
        int c, e, s;
        io_rst = 1'b1;
        cfg_start = 1'b0; cfg_stop = 1'b0; cfg_trigMode = 1'b0; io_trigIn = 1'b0;
        cfg_trigDelay = '0; cfg_period = '0; cfg_pulseWidth = '0; cfg_count = '0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_pulse_en", pulse_en, 0);
        chk("rst_width", pulse_width, 0);
        chk("rst_cnt", pulse_cnt, 0);
        chk("rst_flags", {pwm_dis, done, cfg_err}, 0);
        io_rst = 1'b0;
        tick(2);

        // Basic burst: D=5, P=20, W=4, N=3
        burst_a("s1");

        // Valid-limited spacing: P=2, W=10, N=2
        drive_start(1'b0, 0, 2, 10, 2, c);
        exp_w = 10;
        exp_fire.push_back(c + 1);
        exp_fire.push_back(c + 14);
        exp_done.push_back(c + 27);
        release_start();
        tick(35);
        chk("s2_cnt", pulse_cnt, 2);
        chk("s2_busy", busy, 0);
        chk("s2_fire_left", exp_fire.size(), 0);

        // Trigger mode, D=0, W=3, P=0, N=2; second edge mid-burst ignored
        drive_start(1'b1, 0, 0, 3, 2, c);
        exp_w = 3;
        release_start();
        tick(10);
        chk("s3_armed_busy", busy, 1);
        e = cyc;
        io_trigIn = 1'b1;
        exp_fire.push_back(e + 4);
        exp_fire.push_back(e + 10);
        exp_done.push_back(e + 16);
        tick(6);
        io_trigIn = 1'b0;
        tick(2);
        io_trigIn = 1'b1;
        tick(18);
        io_trigIn = 1'b0;
        chk("s3_cnt", pulse_cnt, 2);
        chk("s3_busy", busy, 0);
        chk("s3_fire_left", exp_fire.size(), 0);
        chk("s3_done_left", exp_done.size(), 0);

        // Continuous P=8, W=2, stopped in GAP after the second pulse
        drive_start(1'b0, 0, 8, 2, 0, c);
        exp_w = 2;
        exp_fire.push_back(c + 1);
        exp_fire.push_back(c + 9);
        release_start();
        tick(10);
        s = cyc;
        cfg_stop = 1'b1;
        @(negedge io_clk);
        cfg_stop = 1'b0;
        chk("s4_stop_cycle", cyc, s + 1);
        chk("s4_pwm_dis", pwm_dis, 1);
        chk("s4_busy", busy, 0);
        chk("s4_cnt_at_stop", pulse_cnt, 1);
        tick(1);
        chk("s4_pwm_dis_one", pwm_dis, 0);
        tick(20);
        chk("s4_cnt_frozen", pulse_cnt, 1);
        chk("s4_fire_left", exp_fire.size(), 0);

        // Zero width rejected; start+stop together from IDLE does nothing
        drive_start(1'b0, 0, 4, 0, 1, c);
        @(negedge io_clk);
        cfg_start = 1'b0;
        chk("s5_cfg_err", cfg_err, 1);
        chk("s5_busy", busy, 0);
        tick(1);
        chk("s5_cfg_err_one", cfg_err, 0);
        drive_start(1'b0, 0, 4, 3, 1, c);
        cfg_stop = 1'b1;
        @(negedge io_clk);
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        chk("s5_ss_busy", busy, 0);
        chk("s5_ss_flags", {pwm_dis, cfg_err, pulse_en}, 0);
        tick(5);
        chk("s5_ss_busy_later", busy, 0);

        // Asynchronous reset while in DELAY, then a fresh burst
        drive_start(1'b0, 5, 20, 4, 3, c);
        release_start();
        tick(1);
        chk("s6_in_delay", busy, 1);
        #2 io_rst = 1'b1;
        #1;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_width", pulse_width, 0);
        chk("s6_rst_outs", {pulse_en, pwm_dis, done, cfg_err}, 0);
        chk("s6_rst_cnt", pulse_cnt, 0);
        @(negedge io_clk);
        io_rst = 1'b0;
        tick(2);
        burst_a("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_sched.md
# pulse_sched

Upstream scheduler for the `sigpulse` pulse generator. It accepts a start command, optionally waits for an external trigger, then applies a programmable trigger delay. It then issues a burst of `N` pulse-load strobes (or an unbounded stream), spaced by a programmable period, and drives `io_en`, `io_pulseWidth` and `pwm_dis` of the downstream `sigpulse`. It consumes `pulse_valid` to count completed pulses and to report burst completion.

## Interface
Parameters:
- `_RAM_WIDTH`, 32: width of delay, period and pulse-width values (cycles).
- `_CNT_WIDTH`, 16: width of burst count and completed-pulse counter.

Ports:
- `io_clk`  in  1  sole clock.
- `io_rst`  in  1  asynchronous, active-high reset.
- `cfg_start`  in  1  one-cycle start command.
- `cfg_stop`  in  1  one-cycle abort command.
- `cfg_trigMode`  in  1  0 = start immediately; 1 = wait for rising edge on `io_trigIn`.
- `cfg_trigDelay`  in  `_RAM_WIDTH`  cycles from start/trigger to first pulse.
- `cfg_period`  in  `_RAM_WIDTH`  minimum cycles between successive `pulse_en`.
- `cfg_pulseWidth`  in  `_RAM_WIDTH`  pulse width forwarded to `sigpulse`; 0 is illegal.
- `cfg_count`  in  `_CNT_WIDTH`  pulses per burst; 0 = continuous.
- `io_trigIn`  in  1  asynchronous external trigger.
- `pulse_en`  out  1  one-cycle load strobe to `sigpulse.io_en`.
- `pulse_width`  out  `_RAM_WIDTH`  to `sigpulse.io_pulseWidth`.
- `pwm_dis`  out  1  to `sigpulse.pwm_dis`.
- `pulse_valid`  in  1  from `sigpulse.pulse_valid`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle burst-complete strobe.
- `cfg_err`  out  1  one-cycle strobe: start rejected.
- `pulse_cnt`  out  `_CNT_WIDTH`  pulses completed in the current or last burst.

## Operation
- Reset values: all outputs 0, state IDLE, shadow registers 0.
- States:
  - IDLE
  - ARM: wait for trigger.
  - DELAY
  - FIRE: emit `pulse_en`.
  - GAP: wait for both period expiry and `pulse_valid`.
- Start handling in IDLE:
  - `cfg_start` with `cfg_pulseWidth == 0` asserts `cfg_err` for 1 cycle and stays in IDLE.
  - Otherwise, `cfg_start` captures every `cfg_*` into shadow registers, clears `pulse_cnt`, then goes to ARM if `cfg_trigMode == 1`, else to DELAY.
  - `cfg_*` changes during a burst have no effect.
- `io_trigIn` passes through a 2-flop synchronizer followed by a rising-edge detector.
  - In ARM, a detected edge moves the block to DELAY.
  - Edges in other states are ignored.
  - One trigger starts one whole burst.
- DELAY: down-counter loaded with the shadow delay. At zero, go to FIRE.
- FIRE: `pulse_en` = 1 for exactly one cycle. The period counter loads `cfg_period`. Go to GAP.
- GAP: the period counter decrements to 0 and saturates there.
  - Each `pulse_valid` increments `pulse_cnt`, which wraps at 2^`_CNT_WIDTH`.
  - If `cfg_count != 0` and the incremented value equals `cfg_count`: `done` = 1 on the next cycle, then go to IDLE.
  - Otherwise, once the period counter is ≤ 1 and the valid for the current pulse has been seen, go to FIRE.
- `pulse_width` follows the shadow pulse width and is stable while `busy`.
- Stop:
  - `cfg_stop` in any non-IDLE state: `pwm_dis` = 1 for exactly the next cycle, state goes to IDLE, no `done`, and `pulse_cnt` is held.
  - In IDLE, `cfg_stop` is ignored.
  - `cfg_stop` and `cfg_start` in the same cycle: stop wins, and start is ignored.
  - `cfg_start` while `busy` is ignored.
- `pulse_valid` is ignored in IDLE, ARM and DELAY. This discards the valid that `sigpulse` raises in response to `pwm_dis`.

## Timing
- Start sampled at cycle T, `cfg_trigMode == 0`, delay D: first `pulse_en` at cycle T+1+D (D = 0 gives T+1).
- Trigger mode: edge on `io_trigIn` meeting setup before cycle E appears as a detected edge at E+2. First `pulse_en` follows at E+3+D.
- Pulse k at cycle F_k, period P: F_{k+1} = max(F_k + P, V_k + 1), where V_k is the cycle of `pulse_valid` for pulse k. P = 0 or 1 therefore means "as soon as valid".
- With `sigpulse` and width W: V_k = F_k + W + 2, so back-to-back spacing is W+3 cycles.
- `done`: the cycle after the final `pulse_valid`. `busy` falls in that same cycle.
- Reset mid-burst: all outputs return to 0 immediately, asynchronously.

## Test plan
- Start with mode 0, D=5, W=4, P=20, N=3 → `pulse_en` at T+6, T+26, T+46; `pulse_width` = 4; `pulse_cnt` reaches 3; one `done` cycle follows the third valid; `busy` = 0 afterwards.
- P=2, W=10, N=2 → second `pulse_en` exactly one cycle after the first `pulse_valid` (spacing 13 cycles).
- Mode 1, D=0 → no `pulse_en` before the `io_trigIn` rising edge; first `pulse_en` at E+3; a second edge during the burst has no effect.
- N=0 continuous with P=8, W=2, then `cfg_stop` during GAP → `pwm_dis` high for 1 cycle, the following `pulse_valid` is not counted, `pulse_cnt` is frozen, no `done`, and no further `pulse_en`.
- `cfg_pulseWidth` = 0 with start → `cfg_err` 1 cycle, `busy` stays 0; start and stop in the same cycle from IDLE → no activity.
- Assert `io_rst` while in DELAY → all outputs 0 immediately; a new start after reset behaves like the first scenario.
